// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults and FSM state encoding for the FIR frame sequencer
package fir_pkg;
    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int SAMPLES_NUM_DEF  = 4;
    localparam int RESULT_WIDTH_DEF = 32;

    typedef enum logic [2:0] {IDLE, START, WAIT, DISCARD, ERROR} fir_state_t;
endpackage

// File: rtl/fir_result_serializer.sv
// fir_result_serializer: holds one FIR result frame and hands it out MSB lane first over valid/ready
module fir_result_serializer
    import fir_pkg::*;
#(
    parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
    parameter int SAMPLES_NUM  = SAMPLES_NUM_DEF
) (
    input  logic                                clkIn,
    input  logic                                nResetIn,
    input  logic                                load,
    input  logic                                flush,
    input  logic [RESULT_WIDTH*SAMPLES_NUM-1:0] data,
    output logic [RESULT_WIDTH-1:0]             result,
    output logic                                valid,
    input  logic                                ready,
    output logic                                empty
);
    localparam int BW = RESULT_WIDTH*SAMPLES_NUM;
    localparam int CW = $clog2(SAMPLES_NUM+1);

    logic [BW-1:0] frame;
    logic [CW-1:0] count;

    assign result = frame[BW-1 -: RESULT_WIDTH];
    assign valid  = count != '0;
    assign empty  = count == '0;

    // Load a whole frame, then shift the next lane into the top slot on every handshake
    always_ff @(posedge clkIn or negedge nResetIn)
        if (!nResetIn) begin
            frame <= '0;
            count <= '0;
        end else if (flush) begin
            frame <= '0;
            count <= '0;
        end else if (load) begin
            frame <= data;
            count <= CW'(SAMPLES_NUM);
        end else if (valid && ready) begin
            frame <= frame << RESULT_WIDTH;
            count <= count - CW'(1);
        end
endmodule

// File: rtl/fir_frame_sequencer.sv
// fir_frame_sequencer: groups stream samples into frames, drives the FIR engine and serializes its results
module fir_frame_sequencer
    import fir_pkg::*;
#(
    parameter int SAMPLE_WIDTH   = SAMPLE_WIDTH_DEF,
    parameter int SAMPLES_NUM    = SAMPLES_NUM_DEF,
    parameter int RESULT_WIDTH   = RESULT_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                clkIn,
    input  logic                                nResetIn,
    input  logic [SAMPLE_WIDTH-1:0]             sampleIn,
    input  logic                                sampleValidIn,
    output logic                                sampleReadyOut,
    output logic [RESULT_WIDTH-1:0]             resultOut,
    output logic                                resultValidOut,
    input  logic                                resultReadyIn,
    input  logic                                flushIn,
    output logic                                errorOut,
    output logic                                firStartOut,
    output logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataOut,
    input  logic                                firBusyIn,
    input  logic                                firDoneIn,
    input  logic [RESULT_WIDTH*SAMPLES_NUM-1:0] firDataIn
);
    localparam int FW = SAMPLE_WIDTH*SAMPLES_NUM;
    localparam int CW = $clog2(SAMPLES_NUM+1);
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [CW-1:0] LAST  = CW'(SAMPLES_NUM-1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES-1);

    fir_state_t    state;
    logic [CW-1:0] asm_count;
    logic [FW-1:0] asm_reg;
    logic [FW-1:0] asm_next;
    logic [FW-1:0] pend_reg;
    logic          pend_valid;
    logic [TW-1:0] wait_count;
    logic          accept;
    logic          out_empty;
    logic          load;
    logic          timeout;

    assign sampleReadyOut = (state != ERROR) && ((asm_count < LAST) || !pend_valid);
    assign accept         = sampleValidIn && sampleReadyOut;
    assign firDataOut     = pend_reg;
    assign load           = (state == WAIT) && firDoneIn && !flushIn;
    assign timeout        = wait_count == TLAST;

    // Splice the incoming sample into its lane so a completed group moves to pending in one edge
    always_comb begin
        asm_next = asm_reg;
        asm_next[int'(asm_count)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sampleIn;
    end

    // Sample assembly and the single-entry pending frame handed to the FIR engine
    always_ff @(posedge clkIn or negedge nResetIn)
        if (!nResetIn) begin
            asm_count  <= '0;
            asm_reg    <= '0;
            pend_reg   <= '0;
            pend_valid <= 1'b0;
        end else if (flushIn) begin
            asm_count  <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (accept) begin
                asm_reg   <= asm_next;
                asm_count <= asm_count == LAST ? '0 : asm_count + CW'(1);
            end
            if (accept && asm_count == LAST) begin
                pend_reg   <= asm_next;
                pend_valid <= 1'b1;
            end else if (state == START) begin
                pend_valid <= 1'b0;
            end
        end

    // Engine handshake FSM with a watchdog on the wait for firDoneIn
    always_ff @(posedge clkIn or negedge nResetIn)
        if (!nResetIn) begin
            state       <= IDLE;
            wait_count  <= '0;
            firStartOut <= 1'b0;
            errorOut    <= 1'b0;
        end else if (flushIn) begin
            state       <= state == WAIT ? DISCARD : IDLE;
            wait_count  <= '0;
            firStartOut <= 1'b0;
            errorOut    <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (pend_valid && out_empty && !firBusyIn) begin
                        state       <= START;
                        firStartOut <= 1'b1;
                    end
                START: begin
                    state       <= WAIT;
                    firStartOut <= 1'b0;
                    wait_count  <= '0;
                end
                WAIT, DISCARD:
                    if (firDoneIn) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        state    <= state == WAIT ? ERROR : IDLE;
                        errorOut <= 1'b1;
                    end else begin
                        wait_count <= wait_count + TW'(1);
                    end
                default: firStartOut <= 1'b0;
            endcase
        end

    fir_result_serializer #(
        .RESULT_WIDTH(RESULT_WIDTH),
        .SAMPLES_NUM (SAMPLES_NUM)
    ) u_serializer (
        .clkIn   (clkIn),
        .nResetIn(nResetIn),
        .load    (load),
        .flush   (flushIn),
        .data    (firDataIn),
        .result  (resultOut),
        .valid   (resultValidOut),
        .ready   (resultReadyIn),
        .empty   (out_empty)
    );
endmodule

// File: doc/fir_frame_sequencer.md
FIR_FRAME_SEQUENCER -- requirements
Module: fir_frame_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, input sample width.
REQ-002 SHALL have parameter SAMPLES_NUM, default 4, samples per FIR group.
REQ-003 SHALL have parameter RESULT_WIDTH, default 32, FIR result width per sample.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles allowed between firStartOut and firDoneIn.
REQ-005 SHALL have port clkIn  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port nResetIn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sampleIn  input  SAMPLE_WIDTH  stream sample.
REQ-008 SHALL have port sampleValidIn  input  1  sampleIn valid.
REQ-009 SHALL have port sampleReadyOut  output  1  sample accepted when valid&&ready at the edge.
REQ-010 SHALL have port resultOut  output  RESULT_WIDTH  serialized FIR result.
REQ-011 SHALL have port resultValidOut  output  1  resultOut valid.
REQ-012 SHALL have port resultReadyIn  input  1  result consumed when valid&&ready at the edge.
REQ-013 SHALL have port flushIn  input  1  synchronous abort of all queued data.
REQ-014 SHALL have port errorOut  output  1  sticky timeout flag.
REQ-015 SHALL have ports firStartOut (output, 1), firDataOut (output, SAMPLE_WIDTH*SAMPLES_NUM), firBusyIn (input, 1), firDoneIn (input, 1), firDataIn (input, RESULT_WIDTH*SAMPLES_NUM), all connecting to the FIR engine.

Function
REQ-016 SHALL pack accepted samples into an assembly register: the k-th accepted sample of a group (k=0 first) occupies bits [16k+15:16k].
REQ-017 SHALL transfer the assembly register to a pending register on the edge that accepts sample SAMPLES_NUM-1, set pendingValid, and clear the assembly count to 0.
REQ-018 SHALL drive sampleReadyOut = (assemblyCount < SAMPLES_NUM-1) || !pendingValid, registered-state-only with no combinational path from any input.
REQ-019 SHALL drive firDataOut from the pending register at all times.
REQ-020 SHALL implement FSM states IDLE, START, WAIT, DISCARD, ERROR.
REQ-021 SHALL transition IDLE->START when pendingValid && output buffer empty && !firBusyIn, giving firStartOut high in the cycle after pendingValid rises, at the earliest.
REQ-022 SHALL assert firStartOut for exactly one cycle (START), clear pendingValid on that edge, and go to WAIT.
REQ-023 SHALL, in WAIT with firDoneIn high, capture firDataIn into the output buffer, set outCount=SAMPLES_NUM, and return to IDLE.
REQ-024 SHALL emit buffered results MSB-lane first: firDataIn[127:96] first, [31:0] last; resultValidOut rises the cycle after firDoneIn is sampled.
REQ-025 SHALL hold resultOut and resultValidOut stable while resultReadyIn is low; each handshake decrements outCount; the buffer is empty at outCount=0.
REQ-026 SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without firDoneIn, enter ERROR and set errorOut.
REQ-027 SHALL, in ERROR, keep firStartOut low and sampleReadyOut low; exit to IDLE only on flushIn or reset; errorOut clears only on flushIn or reset.
REQ-028 SHALL, on flushIn, clear the assembly count, pendingValid, and outCount in the same edge; in WAIT it SHALL go to DISCARD, otherwise to IDLE.
REQ-029 SHALL, in DISCARD, ignore firDataIn, return to IDLE on firDoneIn or on timeout (timeout sets errorOut).
REQ-030 SHALL give flushIn priority over a same-cycle sample accept, result handshake, or firDoneIn.
REQ-031 SHALL allow a sample accept and a pending-register consume on the same edge without data loss.

Reset
REQ-032 SHALL, on nResetIn low, asynchronously force: FSM=IDLE, assemblyCount=0, pendingValid=0, outCount=0, timeout counter=0, firStartOut=0, resultValidOut=0, errorOut=0, sampleReadyOut=1 after release, resultOut=0, firDataOut=0.
REQ-033 SHALL, if reset occurs mid-WAIT, ignore any firDoneIn arriving after release while the FSM is in IDLE.

Structure
REQ-034 SHALL place SAMPLE_WIDTH, SAMPLES_NUM, RESULT_WIDTH defaults and the FSM state enum in the shared package fir_pkg.
REQ-035 SHALL place the output serializer (buffer, outCount, valid/ready) in the sub-module fir_result_serializer; everything else stays in the top level.

Verification
REQ-036 SHALL verify that the samples 0x0001,0x0002,0x0003,0x0004 produce firDataOut=0x0004_0003_0002_0001 with a single one-cycle firStartOut.
REQ-037 SHALL verify that firDataIn=0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD with resultReadyIn held 1 yields AAAAAAAA,BBBBBBBB,CCCCCCCC,DDDDDDDD on 4 consecutive cycles.
REQ-038 SHALL verify that 8 samples sent back-to-back while the FIR stays busy cause sampleReadyOut to drop after sample 7 is accepted, and that the second start is issued only after all 4 results are drained.
REQ-039 SHALL verify that resultReadyIn toggling 1,0,0,1 holds resultOut stable during the stall and loses no word.
REQ-040 SHALL verify that with firDoneIn withheld for 4096 cycles, errorOut=1 and there are no further starts; a subsequent flushIn clears errorOut and returns the FSM to IDLE.
REQ-041 SHALL verify that flushIn in WAIT followed by firDoneIn produces no results, and that the next group is processed normally.
